// File: rtl/pixel_replicator.sv
// Nearest-neighbour replicator: buffers one source row and replays it SCALE times, each pixel
// held SCALE cycles, with a one-cycle gap per replayed row. Optional macro: ROW_PINGPONG_EN.
module pixel_replicator #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 72,
  parameter int unsigned SCALE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] m_pixel,
  output logic        m_valid,
  output logic        frame_done
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RepW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RepW-1:0] RepLast = RepW'(SCALE - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  typedef enum logic [1:0] {StFill, StEmit, StGap} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [ColW-1:0] wcol_q, wcol_d;
  logic [RepW-1:0] rep_h_q, rep_h_d;
  logic [RepW-1:0] rep_v_q, rep_v_d;
  logic [RowW-1:0] row_q, row_d;
  logic            row_done;

  logic            wr_en, wr_last;
  logic            cur_ready, nxt_ready;
  logic [23:0]     rd_pixel;
  logic            s_ready_d, m_valid_d, frame_done_d;
  logic [23:0]     m_pixel_d;

  assign wr_en   = s_valid && s_ready;
  assign wr_last = wr_en && (wcol_q == ColLast);

  always_comb begin
    wcol_d = wcol_q;
    if (wr_en) begin
      wcol_d = wr_last ? '0 : wcol_q + 1'b1;
    end
  end

`ifdef ROW_PINGPONG_EN
  // Two banks: one fills while the other replays; full flags hand a bank across.
  logic [23:0] mem [2][IMG_W];
  logic        fill_sel_q, fill_sel_d;
  logic        emit_sel_q, emit_sel_d;
  logic [1:0]  full_q, full_d;

  assign cur_ready = full_q[emit_sel_q] | (wr_last & (fill_sel_q == emit_sel_q));
  assign nxt_ready = full_q[~emit_sel_q] | (wr_last & (fill_sel_q != emit_sel_q));

  always_comb begin
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    emit_sel_d = emit_sel_q;
    if (row_done) begin
      full_d[emit_sel_q] = 1'b0;
      emit_sel_d         = ~emit_sel_q;
    end
    if (wr_last) begin
      full_d[fill_sel_q] = 1'b1;
      fill_sel_d         = ~fill_sel_q;
    end
  end

  assign s_ready_d = ~full_d[fill_sel_d];
  assign rd_pixel  = mem[emit_sel_d][col_d];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[fill_sel_q][wcol_q] <= s_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_sel_q <= 1'b0;
      emit_sel_q <= 1'b0;
      full_q     <= '0;
    end else begin
      fill_sel_q <= fill_sel_d;
      emit_sel_q <= emit_sel_d;
      full_q     <= full_d;
    end
  end
`else
  logic [23:0] mem [IMG_W];

  assign cur_ready = wr_last;
  assign nxt_ready = 1'b0;
  assign s_ready_d = (state_d == StFill);
  assign rd_pixel  = mem[col_d];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wcol_q] <= s_pixel;
    end
  end
`endif

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFill;
      col_q   <= '0;
      wcol_q  <= '0;
      rep_h_q <= '0;
      rep_v_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      wcol_q  <= wcol_d;
      rep_h_q <= rep_h_d;
      rep_v_q <= rep_v_d;
      row_q   <= row_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    rep_h_d  = rep_h_q;
    rep_v_d  = rep_v_q;
    row_d    = row_q;
    row_done = 1'b0;
    unique case (state_q)
      StFill: begin
        if (cur_ready) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (rep_h_q == RepLast) begin
          rep_h_d = '0;
          if (col_q == ColLast) begin
            col_d   = '0;
            state_d = StGap;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          rep_h_d = rep_h_q + 1'b1;
        end
      end
      StGap: begin
        if (rep_v_q != RepLast) begin
          rep_v_d = rep_v_q + 1'b1;
          state_d = StEmit;
        end else begin
          rep_v_d  = '0;
          row_done = 1'b1;
          state_d  = nxt_ready ? StEmit : StFill;
          row_d    = (row_q == RowLast) ? '0 : row_q + 1'b1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    m_valid_d    = (state_d == StEmit);
    m_pixel_d    = m_valid_d ? rd_pixel : '0;
    frame_done_d = row_done && (row_q == RowLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_pixel    <= '0;
      frame_done <= 1'b0;
    end else begin
      s_ready    <= s_ready_d;
      m_valid    <= m_valid_d;
      m_pixel    <= m_pixel_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pixel_replicator.sv
// Directed self-checking bench for pixel_replicator (IMG_W=4, IMG_H=2, SCALE=3).
module tb_pixel_replicator;

  logic        clk;
  logic        rst_n;
  logic [23:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] m_pixel;
  logic        m_valid;
  logic        frame_done;

  int checks;
  int failures;

  logic [23:0] row_a [4];
  logic [23:0] row_b [4];
  logic [23:0] row_c [4];
  logic [23:0] row_d [4];

  pixel_replicator #(
    .IMG_W(4),
    .IMG_H(2),
    .SCALE(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_pixel   (s_pixel),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_pixel   (m_pixel),
    .m_valid   (m_valid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Feeds four pixels; optionally drops s_valid for stall cycles after the 2nd pixel.
  task automatic send_row(input logic [23:0] p [4], input int stall);
    int waited;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (!s_ready && waited < 200) begin
        tick();
        waited++;
      end
      chk("s_ready_wait", 24'(s_ready), 24'd1);
      s_valid = 1'b1;
      s_pixel = p[i];
      tick();
      if (i == 0) chk("fd_low", 24'(frame_done), 24'd0);
      if (i == 1 && stall > 0) begin
        s_valid = 1'b0;
        s_pixel = 24'hDEAD00;
        for (int k = 0; k < stall; k++) begin
          tick();
          chk("stall_ready", 24'(s_ready), 24'd1);
          chk("stall_valid", 24'(m_valid), 24'd0);
        end
      end
    end
    s_valid = 1'b0;
    s_pixel = 24'hBADBAD;
  endtask

  // Expects the 39-cycle replay starting in the current cycle.
  task automatic check_row(input logic [23:0] p [4], input logic fd);
    for (int rv = 0; rv < 3; rv++) begin
      for (int c = 0; c < 4; c++) begin
        for (int h = 0; h < 3; h++) begin
          chk("emit_valid", 24'(m_valid), 24'd1);
          chk("emit_pixel", m_pixel, p[c]);
          chk("emit_fd", 24'(frame_done), 24'd0);
`ifndef ROW_PINGPONG_EN
          chk("emit_ready", 24'(s_ready), 24'd0);
`endif
          tick();
        end
      end
      chk("gap_valid", 24'(m_valid), 24'd0);
      chk("gap_pixel", m_pixel, 24'd0);
      chk("gap_fd", 24'(frame_done), 24'd0);
      tick();
    end
    chk("post_ready", 24'(s_ready), 24'd1);
    chk("post_fd", 24'(frame_done), 24'(fd));
  endtask

`ifdef ROW_PINGPONG_EN
  logic [23:0] pp [8];
  int          pidx;

  task automatic ptick();
    logic xfer;
    xfer = s_ready && s_valid;
    tick();
    if (xfer) pidx++;
    s_valid = (pidx < 8);
    s_pixel = (pidx < 8) ? pp[pidx] : 24'hBADBAD;
  endtask
`endif

  initial begin
    logic [23:0] exp_pix;
    checks   = 0;
    failures = 0;
    row_a = '{24'h000011, 24'h000022, 24'h000033, 24'h000044};
    row_b = '{24'hAAAAAA, 24'hAA00AA, 24'h00AA00, 24'hAAAA00};
    row_c = '{24'hBBBBBB, 24'hBB00BB, 24'h00BB00, 24'hBBBB00};
    row_d = '{24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678};

    // Reset
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_pixel = 24'h0;
    repeat (5) tick();
    chk("rst_ready", 24'(s_ready), 24'd0);
    chk("rst_valid", 24'(m_valid), 24'd0);
    chk("rst_pixel", m_pixel, 24'd0);
    chk("rst_fd", 24'(frame_done), 24'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", 24'(s_ready), 24'd1);

    // Single row (row 0), then stalled row (row 1, ends frame)
    send_row(row_a, 0);
    check_row(row_a, 1'b0);
    send_row(row_a, 7);
    check_row(row_a, 1'b1);

    // Two full frames
    send_row(row_b, 0);
    check_row(row_b, 1'b0);
    send_row(row_c, 0);
    check_row(row_c, 1'b1);
    send_row(row_d, 0);
    check_row(row_d, 1'b0);
    send_row(row_a, 0);
    check_row(row_a, 1'b1);

    // Mid-emit reset during the 2nd replayed row
    send_row(row_b, 0);
    repeat (18) tick();
    chk("pre_rst_valid", 24'(m_valid), 24'd1);
    chk("pre_rst_pixel", m_pixel, row_b[1]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 24'(m_valid), 24'd0);
    chk("mid_rst_pixel", m_pixel, 24'd0);
    chk("mid_rst_ready", 24'(s_ready), 24'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rel2_ready", 24'(s_ready), 24'd1);
    send_row(row_c, 0);
    check_row(row_c, 1'b0);
    send_row(row_d, 0);
    check_row(row_d, 1'b1);

`ifdef ROW_PINGPONG_EN
    // Continuous source: row 2 replay follows row 1's final gap with no dead cycles
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      pp[i]     = row_b[i];
      pp[i + 4] = row_c[i];
    end
    pidx    = 0;
    s_valid = 1'b1;
    s_pixel = pp[0];
    while (pidx < 4 && checks < 100000) ptick();
    for (int t = 0; t < 78; t++) begin
      if ((t % 39) % 13 == 12) begin
        chk("pp_gap_valid", 24'(m_valid), 24'd0);
        chk("pp_gap_pixel", m_pixel, 24'd0);
      end else begin
        exp_pix = (t < 39) ? row_b[((t % 39) % 13) / 3] : row_c[((t % 39) % 13) / 3];
        chk("pp_valid", 24'(m_valid), 24'd1);
        chk("pp_pixel", m_pixel, exp_pix);
      end
      if (t < 39) chk("pp_ready", 24'(s_ready), 24'(t < 4));
      chk("pp_fd", 24'(frame_done), 24'd0);
      ptick();
    end
    chk("pp_frame_done", 24'(frame_done), 24'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
